fpu_sp_issuer: RTL and testbench



---
 rtl/fpu_issuer_pkg.sv | 32 +++
 rtl/fpu_issuer_fifo.sv | 61 ++++++
 rtl/fpu_sp_issuer.sv | 194 +++++++++++++++++++
 tb/tb_fpu_sp_issuer.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issuer_pkg.sv
// Shared definitions for the single-precision FPU issuer: command codes,
// FSM state encoding, the operation record and the quiet-NaN constant.
package fpu_issuer_pkg;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_MUL = 4'd3;
  localparam logic [3:0] CMD_DIV = 4'd4;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RELEASE,
    ST_RESP
  } issuer_state_e;

  // Operation body of a request; the tag is appended by the issuer because
  // its width is a per-instance parameter.
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
  } fpu_op_t;

  function automatic logic cmd_is_legal(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_MUL) || (cmd == CMD_DIV);
  endfunction

endpackage

// File: rtl/fpu_issuer_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending FPU requests.
// DEPTH must be a power of two so the pointers wrap on their own.
module fpu_issuer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; fullness is judged on the pre-pop count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fpu_sp_issuer.sv
// Front-end initiator for fpu_sp_top: queues tagged requests, runs one FPU
// operation at a time through the din/dval -> result/rdy handshake and hands
// each result back with its tag. Optional watchdog: FPU_ISSUER_TIMEOUT_EN.
module fpu_sp_issuer
  import fpu_issuer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [31:0]      fpu_din1,
  output logic [31:0]      fpu_din2,
  output logic [3:0]       fpu_cmd,
  output logic             fpu_dval,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_rdy,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    fpu_op_t          op;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             push_req;
  req_t             head_req;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  issuer_state_e    state;
  issuer_state_e    next_state;

  logic             load_op;
  logic             load_illegal;
  logic             capture_result;
  logic             load_timeout;
  logic             timeout_hit;

  assign req_ready = !rst && !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign push_req  = {req_cmd, req_a, req_b, req_tag};

  fpu_issuer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State register; reset abandons any operation in flight without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the one-cycle strobes that steer the datapath.
  always_comb begin
    next_state     = state;
    fifo_pop       = 1'b0;
    load_op        = 1'b0;
    load_illegal   = 1'b0;
    capture_result = 1'b0;
    load_timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (cmd_is_legal(head_req.op.cmd)) begin
            load_op    = 1'b1;
            next_state = ST_ISSUE;
          end else begin
            load_illegal = 1'b1;
            next_state   = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (fpu_rdy) begin
          capture_result = 1'b1;
          next_state     = ST_RELEASE;
        end else if (timeout_hit) begin
          load_timeout = 1'b1;
          next_state   = ST_RESP;
        end
      end
      ST_RELEASE: begin
        if (!fpu_rdy) begin
          next_state = ST_RESP;
        end else if (timeout_hit) begin
          load_timeout = 1'b1;
          next_state   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Operand/command and response registers, held stable between their loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_din1   <= '0;
      fpu_din2   <= '0;
      fpu_cmd    <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (load_op) begin
        fpu_din1 <= head_req.op.a;
        fpu_din2 <= head_req.op.b;
        fpu_cmd  <= head_req.op.cmd;
        rsp_tag  <= head_req.tag;
      end
      if (load_illegal) begin
        rsp_result <= '0;
        rsp_err    <= 1'b1;
        rsp_tag    <= head_req.tag;
      end
      if (capture_result) begin
        rsp_result <= fpu_result;
        rsp_err    <= 1'b0;
      end
      if (load_timeout) begin
        rsp_result <= QNAN;
        rsp_err    <= 1'b1;
      end
    end
  end

`ifdef FPU_ISSUER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  // Watchdog: counts cycles spent in ISSUE/RELEASE, restarting for each operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (load_op) begin
      to_cnt <= '0;
    end else if (state == ST_ISSUE || state == ST_RELEASE) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == ST_ISSUE || state == ST_RELEASE) &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: the issuer waits for the FPU indefinitely; the parameter is
  // kept so both builds present the same interface.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign fpu_dval  = (state == ST_ISSUE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_fpu_sp_issuer.sv
// Self-checking bench for fpu_sp_issuer driving a behavioural FPU stub.
// The timeout scenario is compiled only when FPU_ISSUER_TIMEOUT_EN is defined.
module tb_fpu_sp_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [31:0] fpu_din1;
  logic [31:0] fpu_din2;
  logic [3:0]  fpu_cmd;
  logic        fpu_dval;
  logic [31:0] fpu_result;
  logic        fpu_rdy;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A12 = 32'h4140_0000;
  localparam logic [31:0] B6  = 32'h40C0_0000;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        err;
  } rsp_rec_t;

  rsp_rec_t rsp_q[$];

  int stub_lat;
  int stub_rdy_len;
  logic stub_hang;
  int stub_cnt;
  logic stub_busy;

  fpu_sp_issuer #(
    .DEPTH          (4),
    .TAG_W          (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .fpu_din1   (fpu_din1),
    .fpu_din2   (fpu_din2),
    .fpu_cmd    (fpu_cmd),
    .fpu_dval   (fpu_dval),
    .fpu_result (fpu_result),
    .fpu_rdy    (fpu_rdy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Known results for 12.0 op 6.0; anything else yields zero.
  function automatic logic [31:0] stub_calc(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    if (a == A12 && b == B6) begin
      case (c)
        4'd1:    return 32'h4190_0000;
        4'd2:    return 32'h40C0_0000;
        4'd3:    return 32'h4290_0000;
        4'd4:    return 32'h4000_0000;
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  // FPU stub: after dval, waits stub_lat cycles, then holds rdy for stub_rdy_len cycles.
  always @(posedge clk) begin
    if (rst) begin
      fpu_rdy    <= 1'b0;
      fpu_result <= '0;
      stub_cnt   <= 0;
      stub_busy  <= 1'b0;
    end else if (!stub_busy) begin
      if (fpu_dval && !stub_hang) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 0;
      end
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == stub_lat) begin
        fpu_rdy    <= 1'b1;
        fpu_result <= stub_calc(fpu_cmd, fpu_din1, fpu_din2);
      end
      if (stub_cnt == stub_lat + stub_rdy_len) begin
        fpu_rdy   <= 1'b0;
        stub_busy <= 1'b0;
      end
    end
  end

  // Response log of every accepted response.
  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_q.push_back({rsp_result, rsp_tag, rsp_err});
    end
  end

  // Offer one request from a negedge and return on the negedge after acceptance.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t);
    int guard = 0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_a     = a;
    req_b     = b;
    req_tag   = t;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send_accept: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b0;
    stub_lat = 2; stub_rdy_len = 1; stub_hang = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req_ready_in_rst: got %b required 0", req_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_req_ready_after: got %b required 1", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_rsp_valid: got %b required 0", rsp_valid);
    end
    checks++;
    if (fpu_dval !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_fpu_dval: got %b required 0", fpu_dval);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy);
    end
    checks++;
    if ({rsp_result, rsp_tag, rsp_err} !== 37'h0) begin
      errors++; $display("[TB] FAIL reset_rsp_fields: got %h/%h/%b required 0", rsp_result, rsp_tag, rsp_err);
    end
    checks++;
    if ({fpu_din1, fpu_din2, fpu_cmd} !== 68'h0) begin
      errors++; $display("[TB] FAIL reset_fpu_regs: got %h/%h/%h required 0", fpu_din1, fpu_din2, fpu_cmd);
    end
    @(negedge clk);
  endtask

  task automatic test_add_latency();
    int guard = 0;
    stub_lat = 2; stub_rdy_len = 1;
    rsp_ready = 1'b1;
    send(4'd1, A12, B6, 4'd3);
    checks++;
    if (fpu_dval !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL add_n1: dval=%b busy=%b required dval 0 busy 1", fpu_dval, busy);
    end
    @(negedge clk);
    checks++;
    if (fpu_dval !== 1'b1) begin
      errors++; $display("[TB] FAIL add_dval_n2: got %b required 1", fpu_dval);
    end
    checks++;
    if (fpu_din1 !== A12 || fpu_din2 !== B6 || fpu_cmd !== 4'd1) begin
      errors++; $display("[TB] FAIL add_operands: got %h %h %h required %h %h 1", fpu_din1, fpu_din2, fpu_cmd, A12, B6);
    end
    while (!fpu_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (fpu_rdy !== 1'b1 || fpu_dval !== 1'b1) begin
      errors++; $display("[TB] FAIL add_rdy_wait: rdy=%b dval=%b required 1 1", fpu_rdy, fpu_dval);
    end
    @(negedge clk);
    checks++;
    if (fpu_dval !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL add_m1: dval=%b rsp_valid=%b required 0 0", fpu_dval, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL add_m2_valid: got %b required 1", rsp_valid);
    end
    checks++;
    if (rsp_result !== 32'h4190_0000 || rsp_tag !== 4'd3 || rsp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL add_response: got %h tag %h err %b required 41900000 tag 3 err 0", rsp_result, rsp_tag, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int base = rsp_q.size();
    int guard = 0;
    logic [31:0] exp_res [3];
    exp_res[0] = 32'h40C0_0000; exp_res[1] = 32'h4290_0000; exp_res[2] = 32'h4000_0000;
    stub_lat = 1; stub_rdy_len = 3;
    rsp_ready = 1'b1;
    send(4'd2, A12, B6, 4'd5);
    send(4'd3, A12, B6, 4'd6);
    send(4'd4, A12, B6, 4'd7);
    while (rsp_q.size() - base < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (rsp_q.size() - base != 3) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d required 3", rsp_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rsp_q[base+i] !== {exp_res[i], 4'(5 + i), 1'b0}) begin
          errors++;
          $display("[TB] FAIL b2b_rsp%0d: got %h tag %h err %b required %h tag %0d err 0",
                   i, rsp_q[base+i].res, rsp_q[base+i].tag, rsp_q[base+i].err, exp_res[i], 5 + i);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_full();
    int base = rsp_q.size();
    int next_i = 0;
    int cyc = 0;
    logic accepted;
    logic [3:0]  cmds    [6];
    logic [31:0] exp_res [6];
    cmds[0] = 4'd1; cmds[1] = 4'd2; cmds[2] = 4'd3; cmds[3] = 4'd4; cmds[4] = 4'd1; cmds[5] = 4'd2;
    exp_res[0] = 32'h4190_0000; exp_res[1] = 32'h40C0_0000; exp_res[2] = 32'h4290_0000;
    exp_res[3] = 32'h4000_0000; exp_res[4] = 32'h4190_0000; exp_res[5] = 32'h40C0_0000;
    stub_lat = 1; stub_rdy_len = 1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (next_i < 6) begin
        req_valid = 1'b1; req_cmd = cmds[next_i]; req_a = A12; req_b = B6; req_tag = 4'(next_i);
      end else begin
        req_valid = 1'b0;
      end
      accepted = req_valid && req_ready;
      @(posedge clk);
      @(negedge clk);
      if (accepted) next_i++;
    end
    checks++;
    if (next_i != 5) begin
      errors++; $display("[TB] FAIL full_accepted: got %0d required 5", next_i);
    end
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL full_ready: req_ready=%b busy=%b required 0 1", req_ready, busy);
    end
    rsp_ready = 1'b1;
    while ((next_i < 6 || rsp_q.size() - base < 6) && cyc < 300) begin
      if (next_i < 6) begin
        req_valid = 1'b1; req_cmd = cmds[next_i]; req_a = A12; req_b = B6; req_tag = 4'(next_i);
      end else begin
        req_valid = 1'b0;
      end
      accepted = req_valid && req_ready;
      @(posedge clk);
      @(negedge clk);
      if (accepted) next_i++;
      cyc++;
    end
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (rsp_q.size() - base != 6) begin
      errors++; $display("[TB] FAIL full_rsp_count: got %0d required 6", rsp_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rsp_q[base+i] !== {exp_res[i], 4'(i), 1'b0}) begin
          errors++;
          $display("[TB] FAIL full_rsp%0d: got %h tag %h err %b required %h tag %0d err 0",
                   i, rsp_q[base+i].res, rsp_q[base+i].tag, rsp_q[base+i].err, exp_res[i], i);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL full_drained_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_resp_to_issue();
    int guard = 0;
    stub_lat = 1; stub_rdy_len = 1;
    rsp_ready = 1'b0;
    send(4'd1, A12, B6, 4'd10);
    send(4'd3, A12, B6, 4'd11);
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 4'd10) begin
      errors++; $display("[TB] FAIL r2i_first: valid=%b tag=%h required 1 a", rsp_valid, rsp_tag);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || fpu_dval !== 1'b0) begin
      errors++; $display("[TB] FAIL r2i_r1: valid=%b dval=%b required 0 0", rsp_valid, fpu_dval);
    end
    @(negedge clk);
    checks++;
    if (fpu_dval !== 1'b1 || fpu_cmd !== 4'd3) begin
      errors++; $display("[TB] FAIL r2i_r2: dval=%b cmd=%h required 1 3", fpu_dval, fpu_cmd);
    end
    rsp_ready = 1'b1;
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy !== 1'b0 || rsp_q.size() == 0 || rsp_q[rsp_q.size()-1] !== {32'h4290_0000, 4'd11, 1'b0}) begin
      errors++; $display("[TB] FAIL r2i_second: busy=%b last_rsp=%h required busy 0 rsp 42900000 tag b", busy,
                         (rsp_q.size() == 0) ? 37'h0 : rsp_q[rsp_q.size()-1]);
    end
  endtask

  task automatic test_illegal();
    logic saw_dval = 1'b0;
    rsp_ready = 1'b0;
    send(4'hF, A12, B6, 4'd9);
    saw_dval = saw_dval | fpu_dval;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_pop_cycle: rsp_valid=%b required 0", rsp_valid);
    end
    @(negedge clk);
    saw_dval = saw_dval | fpu_dval;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL illegal_valid: got %b required 1", rsp_valid);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_result !== 32'h0 || rsp_tag !== 4'd9) begin
      errors++; $display("[TB] FAIL illegal_fields: err=%b result=%h tag=%h required 1 0 9", rsp_err, rsp_result, rsp_tag);
    end
    repeat (3) begin
      @(negedge clk);
      saw_dval = saw_dval | fpu_dval;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    saw_dval = saw_dval | fpu_dval;
    checks++;
    if (saw_dval !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_dval: saw dval=%b required 0", saw_dval);
    end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_done: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset_mid_issue();
    int base;
    int guard = 0;
    logic saw_dval = 1'b0;
    stub_hang = 1'b1;
    rsp_ready = 1'b0;
    send(4'd1, A12, B6, 4'd12);
    send(4'd2, A12, B6, 4'd13);
    while (!fpu_dval && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (fpu_dval !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_in_issue: dval=%b required 1", fpu_dval);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_req_ready: got %b required 0", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (fpu_dval !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_after: dval=%b valid=%b busy=%b required 0 0 0", fpu_dval, rsp_valid, busy);
    end
    checks++;
    if (fpu_din1 !== 32'h0 || fpu_cmd !== 4'h0 || rsp_tag !== 4'h0) begin
      errors++; $display("[TB] FAIL rstmid_regs: din1=%h cmd=%h tag=%h required 0", fpu_din1, fpu_cmd, rsp_tag);
    end
    base = rsp_q.size();
    stub_hang = 1'b0;
    rsp_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      saw_dval = saw_dval | fpu_dval;
    end
    checks++;
    if (rsp_q.size() != base || saw_dval !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_stale: new_rsps=%0d dval_seen=%b busy=%b required 0 0 0",
                         rsp_q.size() - base, saw_dval, busy);
    end
  endtask

`ifdef FPU_ISSUER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    stub_hang = 1'b1;
    rsp_ready = 1'b0;
    send(4'd1, A12, B6, 4'd2);
    @(negedge clk);
    checks++;
    if (fpu_dval !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_dval_rise: got %b required 1", fpu_dval);
    end
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++; $display("[TB] FAIL timeout_latency: got %0d cycles required 16", n);
    end
    checks++;
    if (rsp_result !== 32'h7FC0_0000 || rsp_err !== 1'b1 || rsp_tag !== 4'd2 || fpu_dval !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_fields: result=%h err=%b tag=%h dval=%b required 7fc00000 1 2 0",
                         rsp_result, rsp_err, rsp_tag, fpu_dval);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    stub_hang = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL global_watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting fpu_sp_issuer bench");
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_full();
    test_resp_to_issue();
    test_illegal();
    test_reset_mid_issue();
`ifdef FPU_ISSUER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
